mc_controller: RTL

Multicycle MIPS control unit. It sequences each instruction through fetch, decode, execute, memory and writeback states, and drives the datapath enables and multiplexer selects. It also produces the 3-bit `alucontrol` consumed by the ALU and takes the ALU's `zero` flag back for branch resolution. It sits directly upstream of the ALU in the multicycle datapath.

---
 rtl/mips_pkg.sv | 46 ++++
 rtl/aludec.sv | 43 ++++
 rtl/mc_controller.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS control path.
// Contents: FSM state enum, opcode/funct constants, aluop encoding,
// alucontrol encodings.
package mips_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXECUTE,
        S_ALUWB,
        S_BRANCH,
        S_ADDIEX,
        S_ADDIWB,
        S_JUMP
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    localparam logic [2:0] ALUC_AND = 3'b000;
    localparam logic [2:0] ALUC_OR  = 3'b001;
    localparam logic [2:0] ALUC_ADD = 3'b010;
    localparam logic [2:0] ALUC_SUB = 3'b110;
    localparam logic [2:0] ALUC_SLT = 3'b111;

endpackage

// File: rtl/aludec.sv
// ALU decoder: maps (aluop, funct) to the 3-bit ALU control word.
// Ports:
//   aluop       in  2  add / sub / use funct
//   funct       in  6  instr[5:0]
//   alucontrol  out 3  {invert srcb + carry-in, result select}
//   funct_valid out 1  funct is one of the supported R-type operations
module aludec
    import mips_pkg::*;
(
    input  aluop_t      aluop,
    input  logic [5:0]  funct,
    output logic [2:0]  alucontrol,
    output logic        funct_valid
);

    always_comb begin
        funct_valid = 1'b0;
        case (funct)
            FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: funct_valid = 1'b1;
            default:                               funct_valid = 1'b0;
        endcase
    end

    always_comb begin
        alucontrol = ALUC_ADD;
        case (aluop)
            ALUOP_ADD: alucontrol = ALUC_ADD;
            ALUOP_SUB: alucontrol = ALUC_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FN_ADD:  alucontrol = ALUC_ADD;
                    FN_SUB:  alucontrol = ALUC_SUB;
                    FN_AND:  alucontrol = ALUC_AND;
                    FN_OR:   alucontrol = ALUC_OR;
                    FN_SLT:  alucontrol = ALUC_SLT;
                    default: alucontrol = ALUC_ADD;
                endcase
            end
            default: alucontrol = ALUC_ADD;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS control unit: sequences each instruction through the
// FSM below and drives datapath enables / mux selects.
// Ports:
//   clk, reset (sync, active high), op, funct, zero (ALU flag)
//   alucontrol, alusrca, alusrcb, pcsrc, pcen, iord, memwrite, irwrite,
//   regwrite, regdst, memtoreg, illegal (one-cycle pulse in DECODE)
//
// state   | meaning
// FETCH   | read instruction, PC += 4
// DECODE  | register read, branch target precompute, dispatch
// MEMADR  | lw/sw address = regA + signimm
// MEMRD   | data memory read
// MEMWB   | load data to register file
// MEMWR   | data memory write
// EXECUTE | R-type ALU operation
// ALUWB   | R-type result to rd
// BRANCH  | beq compare, PC <= target if zero
// ADDIEX  | regA + signimm
// ADDIWB  | addi result to rt
// JUMP    | PC <= jump target
module mc_controller
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  op,
    input  logic [5:0]  funct,
    input  logic        zero,
    output logic [2:0]  alucontrol,
    output logic        alusrca,
    output logic [1:0]  alusrcb,
    output logic [1:0]  pcsrc,
    output logic        pcen,
    output logic        iord,
    output logic        memwrite,
    output logic        irwrite,
    output logic        regwrite,
    output logic        regdst,
    output logic        memtoreg,
    output logic        illegal
);

    state_t state;
    aluop_t aluop;
    logic   pcwrite;
    logic   branch;
    logic   funct_valid;
    logic   op_legal;

    aludec u_aludec (
        .aluop       (aluop),
        .funct       (funct),
        .alucontrol  (alucontrol),
        .funct_valid (funct_valid)
    );

    // R-type legality folds in the funct check so EXECUTE is never
    // entered for an unsupported funct.
    always_comb begin
        op_legal = 1'b0;
        case (op)
            OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: op_legal = 1'b1;
            OP_RTYPE:                            op_legal = funct_valid;
            default:                             op_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_FETCH;
        end else begin
            case (state)
                S_FETCH:  state <= S_DECODE;
                S_DECODE: begin
                    if (!op_legal) begin
                        state <= S_FETCH;
                    end else begin
                        case (op)
                            OP_LW, OP_SW: state <= S_MEMADR;
                            OP_RTYPE:     state <= S_EXECUTE;
                            OP_BEQ:       state <= S_BRANCH;
                            OP_ADDI:      state <= S_ADDIEX;
                            OP_J:         state <= S_JUMP;
                            default:      state <= S_FETCH;
                        endcase
                    end
                end
                S_MEMADR:  state <= (op == OP_LW) ? S_MEMRD : S_MEMWR;
                S_MEMRD:   state <= S_MEMWB;
                S_EXECUTE: state <= S_ALUWB;
                S_ADDIEX:  state <= S_ADDIWB;
                default:   state <= S_FETCH;
            endcase
        end
    end

    // Moore decode; reset overrides with FETCH selects and all writes off
    // so an aborted instruction cannot write in the reset cycle.
    always_comb begin
        aluop    = ALUOP_ADD;
        alusrca  = 1'b0;
        alusrcb  = 2'b00;
        pcsrc    = 2'b00;
        pcwrite  = 1'b0;
        branch   = 1'b0;
        iord     = 1'b0;
        memwrite = 1'b0;
        irwrite  = 1'b0;
        regwrite = 1'b0;
        regdst   = 1'b0;
        memtoreg = 1'b0;
        case (state)
            S_FETCH: begin
                irwrite = 1'b1;
                pcwrite = 1'b1;
                alusrcb = 2'b01;
            end
            S_DECODE:  alusrcb = 2'b11;
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_MEMRD:   iord = 1'b1;
            S_MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            S_MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            S_EXECUTE: begin
                alusrca = 1'b1;
                aluop   = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            S_BRANCH: begin
                alusrca = 1'b1;
                aluop   = ALUOP_SUB;
                pcsrc   = 2'b01;
                branch  = 1'b1;
            end
            S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_ADDIWB:  regwrite = 1'b1;
            S_JUMP: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
            end
            default: ;
        endcase
        if (reset) begin
            aluop    = ALUOP_ADD;
            alusrca  = 1'b0;
            alusrcb  = 2'b01;
            pcsrc    = 2'b00;
            pcwrite  = 1'b0;
            branch   = 1'b0;
            iord     = 1'b0;
            memwrite = 1'b0;
            irwrite  = 1'b0;
            regwrite = 1'b0;
            regdst   = 1'b0;
            memtoreg = 1'b0;
        end
    end

    assign pcen    = pcwrite | (branch & zero);
    assign illegal = (state == S_DECODE) && !op_legal && !reset;

endmodule
